// File: rtl/halt_ctrl.sv
// Simulation-termination sequencer: detects ebreak or a commit-stall watchdog expiry,
// freezes the core for a fixed drain window, then raises a sticky halt with an exit code.
module halt_ctrl #(
   parameter int unsigned XLEN         = 64,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned WDOG_W       = 20
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            commit_valid,
   input  logic [31:0]     commit_inst,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [XLEN-1:0] commit_a0,
   output logic            stall,
   output logic            halt,
   output logic [1:0]      halt_code,
   output logic [XLEN-1:0] exit_value,
   output logic [XLEN-1:0] halt_pc,
   output logic [XLEN-1:0] cycle_cnt,
   output logic [XLEN-1:0] inst_cnt
);

   localparam logic [31:0]       EbreakInst = 32'h0010_0073;
   localparam logic [WDOG_W-1:0] WdogMax    = '1;
   localparam logic [7:0]        DrainLast  = 8'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

   state_e            r_state;
   logic              r_stall;
   logic              r_halt;
   logic [1:0]        r_halt_code;
   logic [XLEN-1:0]   r_exit_value;
   logic [XLEN-1:0]   r_halt_pc;
   logic [XLEN-1:0]   r_cycle_cnt;
   logic [XLEN-1:0]   r_inst_cnt;
   logic [XLEN-1:0]   r_last_pc;
   logic [WDOG_W-1:0] r_wdog;
   logic [7:0]        r_drain;

   logic w_ebreak;
   logic w_timeout;

   assign w_ebreak  = commit_valid && (commit_inst == EbreakInst);
   // A commit in the expiry cycle rescues the run.
   assign w_timeout = !commit_valid && (r_wdog == WdogMax);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StRun;
         r_stall      <= 1'b0;
         r_halt       <= 1'b0;
         r_halt_code  <= 2'd0;
         r_exit_value <= '0;
         r_halt_pc    <= '0;
         r_cycle_cnt  <= '0;
         r_inst_cnt   <= '0;
         r_last_pc    <= '0;
         r_wdog       <= '0;
         r_drain      <= 8'd0;
      end else begin
         unique case (r_state)
            StRun: begin
               r_cycle_cnt <= r_cycle_cnt + XLEN'(1);
               if (commit_valid) begin
                  r_inst_cnt <= r_inst_cnt + XLEN'(1);
                  r_wdog     <= '0;
                  r_last_pc  <= commit_pc;
               end else begin
                  r_wdog <= r_wdog + WDOG_W'(1);
               end
               if (w_ebreak) begin
                  r_halt_code  <= (commit_a0 == '0) ? 2'd1 : 2'd2;
                  r_exit_value <= commit_a0;
                  r_halt_pc    <= commit_pc;
                  r_stall      <= 1'b1;
                  r_drain      <= 8'd0;
                  r_state      <= StDrain;
               end else if (w_timeout) begin
                  r_halt_code  <= 2'd3;
                  r_exit_value <= '0;
                  r_halt_pc    <= r_last_pc;
                  r_stall      <= 1'b1;
                  r_drain      <= 8'd0;
                  r_state      <= StDrain;
               end
            end
            StDrain: begin
               // Commits are dropped here; the core is expected to honour stall.
               if (r_drain == DrainLast) begin
                  r_halt  <= 1'b1;
                  r_state <= StHalted;
               end else begin
                  r_drain <= r_drain + 8'd1;
               end
            end
            StHalted: begin
               r_halt <= 1'b1;
            end
            default: begin
               r_state <= StRun;
            end
         endcase
      end
   end

   assign stall      = r_stall;
   assign halt       = r_halt;
   assign halt_code  = r_halt_code;
   assign exit_value = r_exit_value;
   assign halt_pc    = r_halt_pc;
   assign cycle_cnt  = r_cycle_cnt;
   assign inst_cnt   = r_inst_cnt;

endmodule

// File: tb/tb_halt_ctrl.sv
// Scoreboard bench for halt_ctrl: stimulus queues expected halt events, a negedge monitor
// pops and compares them when stall/halt rise.
module tb_halt_ctrl;

   localparam logic [31:0] Nop    = 32'h0000_0013;
   localparam logic [31:0] Ebreak = 32'h0010_0073;

   logic        clk = 1'b0;
   logic        rst_n, rst_b_n;
   logic        commit_valid;
   logic [31:0] commit_inst;
   logic [63:0] commit_pc, commit_a0;

   logic        stall, halt;
   logic [1:0]  halt_code;
   logic [63:0] exit_value, halt_pc, cycle_cnt, inst_cnt;

   logic        stall_b, halt_b;
   logic [1:0]  halt_code_b;
   logic [63:0] exit_value_b, halt_pc_b, cycle_cnt_b, inst_cnt_b;

   always #5 clk = ~clk;

   halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(4), .WDOG_W(4)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .commit_valid (commit_valid),
      .commit_inst  (commit_inst),
      .commit_pc    (commit_pc),
      .commit_a0    (commit_a0),
      .stall        (stall),
      .halt         (halt),
      .halt_code    (halt_code),
      .exit_value   (exit_value),
      .halt_pc      (halt_pc),
      .cycle_cnt    (cycle_cnt),
      .inst_cnt     (inst_cnt)
   );

   halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(1), .WDOG_W(4)) u_dut_d1 (
      .clk          (clk),
      .rst_n        (rst_b_n),
      .commit_valid (commit_valid),
      .commit_inst  (commit_inst),
      .commit_pc    (commit_pc),
      .commit_a0    (commit_a0),
      .stall        (stall_b),
      .halt         (halt_b),
      .halt_code    (halt_code_b),
      .exit_value   (exit_value_b),
      .halt_pc      (halt_pc_b),
      .cycle_cnt    (cycle_cnt_b),
      .inst_cnt     (inst_cnt_b)
   );

   typedef struct {
      string       name;
      int          ecyc;
      logic [1:0]  code;
      logic [63:0] val;
      logic [63:0] pc;
      logic [63:0] inst;
      logic [63:0] ccnt;
   } exp_t;

   exp_t q_stall[$];
   exp_t q_halt[$];
   exp_t q_b[$];
   exp_t e_s, e_h, e_b;

   int   cyc = 0;
   int   r0 = 0;
   int   checks = 0;
   int   failures = 0;
   logic p_stall = 1'b0, p_halt = 1'b0, p_halt_b = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string tag, input string what,
                               input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, what, act, exp);
      end
   endfunction

   function automatic void cmp_rec(input exp_t e, input string ev);
      chk(e.name, {ev, "_cycle"}, 64'(cyc), 64'(e.ecyc));
      chk(e.name, {ev, "_code"}, 64'(halt_code), 64'(e.code));
      chk(e.name, {ev, "_exit_value"}, exit_value, e.val);
      chk(e.name, {ev, "_halt_pc"}, halt_pc, e.pc);
      chk(e.name, {ev, "_inst_cnt"}, inst_cnt, e.inst);
      chk(e.name, {ev, "_cycle_cnt"}, cycle_cnt, e.ccnt);
   endfunction

   // Monitor for the DRAIN_CYCLES=4 instance.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall && !p_stall) begin
            if (q_stall.size() == 0) chk("mon", "unexpected_stall", 64'd1, 64'd0);
            else begin
               e_s = q_stall.pop_front();
               cmp_rec(e_s, "stall");
            end
         end
         if (halt && !p_halt) begin
            if (q_halt.size() == 0) chk("mon", "unexpected_halt", 64'd1, 64'd0);
            else begin
               e_h = q_halt.pop_front();
               cmp_rec(e_h, "halt");
               chk(e_h.name, "halt_stall", 64'(stall), 64'd1);
            end
         end
      end
      p_stall <= stall;
      p_halt  <= halt;
   end

   // Monitor for the DRAIN_CYCLES=1 instance.
   always @(negedge clk) begin
      if (rst_b_n && halt_b && !p_halt_b) begin
         if (q_b.size() == 0) chk("mon_b", "unexpected_halt", 64'd1, 64'd0);
         else begin
            e_b = q_b.pop_front();
            chk(e_b.name, "halt_cycle", 64'(cyc), 64'(e_b.ecyc));
            chk(e_b.name, "halt_code", 64'(halt_code_b), 64'(e_b.code));
            chk(e_b.name, "halt_pc", halt_pc_b, e_b.pc);
            chk(e_b.name, "exit_value", exit_value_b, e_b.val);
         end
      end
      p_halt_b <= halt_b;
   end

   task automatic push_exp(input string name, input int ecyc, input logic [1:0] code,
                           input logic [63:0] val, input logic [63:0] pc,
                           input logic [63:0] inst, input bit with_halt);
      exp_t e;
      e.name = name;
      e.ecyc = ecyc;
      e.code = code;
      e.val  = val;
      e.pc   = pc;
      e.inst = inst;
      e.ccnt = 64'(ecyc - r0);
      q_stall.push_back(e);
      if (with_halt) begin
         e.ecyc = ecyc + 4;
         q_halt.push_back(e);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] a0);
      commit_valid = v;
      commit_inst  = inst;
      commit_pc    = pc;
      commit_a0    = a0;
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      commit_inst  = 32'd0;
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      commit_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      r0    = cyc;
   endtask

   task automatic wait_halt(input string tag, input int bound, input bit use_b);
      for (int i = 0; i < bound; i++) begin
         if (use_b ? halt_b : halt) break;
         @(posedge clk);
         #1;
      end
      chk(tag, "halt_within_bound", 64'(use_b ? halt_b : halt), 64'd1);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, "stall", 64'(stall), 64'd0);
      chk(tag, "halt", 64'(halt), 64'd0);
      chk(tag, "halt_code", 64'(halt_code), 64'd0);
      chk(tag, "exit_value", exit_value, 64'd0);
      chk(tag, "halt_pc", halt_pc, 64'd0);
      chk(tag, "cycle_cnt", cycle_cnt, 64'd0);
      chk(tag, "inst_cnt", inst_cnt, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      rst_n        = 1'b0;
      rst_b_n      = 1'b0;
      commit_valid = 1'b0;
      commit_inst  = 32'd0;
      commit_pc    = 64'd0;
      commit_a0    = 64'd0;
      #12;
      chk_zero("reset");

      // Good trap: 10 commits then ebreak with a0 = 0.
      do_reset();
      for (int i = 0; i < 10; i++) drive(1'b1, Nop, 64'h8000_0000 + 64'(4 * i), 64'(i + 1));
      push_exp("good", cyc + 1, 2'd1, 64'd0, 64'h8000_0028, 64'd11, 1'b1);
      drive(1'b1, Ebreak, 64'h8000_0028, 64'd0);
      wait_halt("good", 20, 1'b0);

      // Bad trap, then a second ebreak and a commit inside DRAIN that must be ignored.
      do_reset();
      drive(1'b1, Nop, 64'h1000, 64'd0);
      drive(1'b1, Nop, 64'h1004, 64'd0);
      push_exp("bad", cyc + 1, 2'd2, 64'h2A, 64'h1008, 64'd3, 1'b1);
      drive(1'b1, Ebreak, 64'h1008, 64'h2A);
      drive(1'b1, Ebreak, 64'h100C, 64'd0);
      drive(1'b1, Nop, 64'h1010, 64'd0);
      wait_halt("bad", 20, 1'b0);

      // Lookalikes: ecall and an addi with ebreak's upper bits.
      do_reset();
      drive(1'b1, 32'h0000_0073, 64'h2000, 64'd0);
      drive(1'b1, 32'h0010_0013, 64'h2004, 64'd5);
      repeat (3) drive(1'b0, 32'd0, 64'd0, 64'd0);
      chk("lookalike", "stall", 64'(stall), 64'd0);
      chk("lookalike", "inst_cnt", inst_cnt, 64'd2);
      chk("lookalike", "halt_code", 64'(halt_code), 64'd0);

      // Timeout: WDOG_W=4, expiry seen 16 edges after the last commit.
      do_reset();
      drive(1'b1, Nop, 64'h100, 64'h55);
      push_exp("timeout", cyc + 16, 2'd3, 64'd0, 64'h100, 64'd1, 1'b1);
      wait_halt("timeout", 40, 1'b0);

      // Commit on the expiry cycle prevents the timeout.
      do_reset();
      drive(1'b1, Nop, 64'h200, 64'd0);
      repeat (15) drive(1'b0, 32'd0, 64'd0, 64'd0);
      drive(1'b1, Nop, 64'h204, 64'd0);
      repeat (10) drive(1'b0, 32'd0, 64'd0, 64'd0);
      chk("no_timeout", "stall", 64'(stall), 64'd0);
      chk("no_timeout", "inst_cnt", inst_cnt, 64'd2);
      chk("no_timeout", "halt_code", 64'(halt_code), 64'd0);

      // Asynchronous reset in the middle of DRAIN, then a clean run.
      do_reset();
      drive(1'b1, Nop, 64'h300, 64'd0);
      push_exp("arst", cyc + 1, 2'd2, 64'd7, 64'h304, 64'd2, 1'b0);
      drive(1'b1, Ebreak, 64'h304, 64'd7);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero("arst");
      do_reset();
      push_exp("arst_rerun", cyc + 1, 2'd1, 64'd0, 64'h400, 64'd1, 1'b1);
      drive(1'b1, Ebreak, 64'h400, 64'd0);
      wait_halt("arst_rerun", 20, 1'b0);

      // DRAIN_CYCLES=1 instance: halt one edge after the ebreak edge.
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      rst_b_n = 1'b1;
      drive(1'b1, Nop, 64'h4FC, 64'd0);
      begin
         exp_t e;
         e.name = "drain1";
         e.ecyc = cyc + 2;
         e.code = 2'd2;
         e.val  = 64'd9;
         e.pc   = 64'h500;
         e.inst = 64'd2;
         e.ccnt = 64'd0;
         q_b.push_back(e);
      end
      drive(1'b1, Ebreak, 64'h500, 64'd9);
      wait_halt("drain1", 10, 1'b1);
      rst_b_n = 1'b0;

      repeat (3) @(posedge clk);
      chk("end", "q_stall_empty", 64'(q_stall.size()), 64'd0);
      chk("end", "q_halt_empty", 64'(q_halt.size()), 64'd0);
      chk("end", "q_b_empty", 64'(q_b.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
